i2s_slave_rx: RTL and testbench

I2S_SLAVE_RX -- requirements
Module: i2s_slave_rx

---
 rtl/i2s_slave_rx.sv | 110 +++++++++++
 tb/tb_i2s_slave_rx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_slave_rx.sv
// I2S receiver running entirely in the mclk domain. It oversamples sclk/ws/sd,
// aligns to the first ws fall, and presents each complete L/R pair together.
module i2s_slave_rx #(
  parameter int d_width       = 24,
  parameter int sclk_ws_ratio = 64
) (
  input  logic               mclk,
  input  logic               reset,
  input  logic               i_sclk,
  input  logic               i_ws,
  input  logic               i_sd,
  output logic [d_width-1:0] o_l_data,
  output logic [d_width-1:0] o_r_data,
  output logic               o_data_valid,
  output logic               o_frame_error
);

  localparam int HALF = sclk_ws_ratio / 2;
  localparam int CW   = $clog2(HALF + 2);
  localparam logic [CW-1:0] W_C    = CW'(d_width);
  localparam logic [CW-1:0] HALF_C = CW'(HALF);
  localparam logic [CW-1:0] SAT_C  = CW'(HALF + 1);

  typedef enum logic [1:0] {ALIGN, LEFT, RIGHT} state_t;
  state_t state, state_n;

  logic               sclk_s1, sclk_s2, sclk_h;
  logic               ws_s1, ws_s2, sd_s1, sd_s2;
  logic               ws_prev, left_ok;
  logic [CW-1:0]      cnt;
  logic [d_width-1:0] sr, hold;

  logic rise_ev, ws_fall, ws_rise, slot_ok;
  assign rise_ev = sclk_s2 & ~sclk_h;
  assign ws_fall = ~ws_s2 & ws_prev;
  assign ws_rise = ws_s2 & ~ws_prev;
  // A slot is good when it carried at least a full word and did not overrun.
  assign slot_ok = (cnt >= W_C) && (cnt <= HALF_C);

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) state <= ALIGN;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (rise_ev) begin
      case (state)
        ALIGN:   if (ws_fall) state_n = LEFT;
        LEFT:    if (ws_rise) state_n = RIGHT;
        RIGHT:   if (ws_fall) state_n = LEFT;
        default: state_n = ALIGN;
      endcase
    end
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      sclk_s1       <= 1'b0;
      sclk_s2       <= 1'b0;
      sclk_h        <= 1'b0;
      ws_s1         <= 1'b0;
      ws_s2         <= 1'b0;
      sd_s1         <= 1'b0;
      sd_s2         <= 1'b0;
      ws_prev       <= 1'b1;
      left_ok       <= 1'b0;
      cnt           <= '0;
      sr            <= '0;
      hold          <= '0;
      o_l_data      <= '0;
      o_r_data      <= '0;
      o_data_valid  <= 1'b0;
      o_frame_error <= 1'b0;
    end else begin
      sclk_s1       <= i_sclk;
      sclk_s2       <= sclk_s1;
      sclk_h        <= sclk_s2;
      ws_s1         <= i_ws;
      ws_s2         <= ws_s1;
      sd_s1         <= i_sd;
      sd_s2         <= sd_s1;
      o_data_valid  <= 1'b0;
      o_frame_error <= 1'b0;
      if (rise_ev) begin
        ws_prev <= ws_s2;
        // The bit at a ws change belongs to the previous slot and is dropped.
        if (state == ALIGN) begin
          cnt     <= '0;
          left_ok <= 1'b0;
        end else if ((state == LEFT && ws_rise) || (state == RIGHT && ws_fall)) begin
          cnt           <= '0;
          o_frame_error <= ~slot_ok;
          if (state == LEFT) begin
            left_ok <= slot_ok;
            if (slot_ok) hold <= sr;
          end else if (slot_ok && left_ok) begin
            o_l_data     <= hold;
            o_r_data     <= sr;
            o_data_valid <= 1'b1;
          end
        end else begin
          if (cnt < W_C)   sr  <= {sr[d_width-2:0], sd_s2};
          if (cnt < SAT_C) cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_slave_rx.sv
// Directed bench for i2s_slave_rx: mclk = 4x sclk, 64 sclk per frame, 24-bit words.
module tb_i2s_slave_rx;

  logic        mclk = 1'b0;
  logic        reset = 1'b1;
  logic        i_sclk = 1'b0;
  logic        i_ws = 1'b1;
  logic        i_sd = 1'b0;
  logic [23:0] o_l_data, o_r_data;
  logic        o_data_valid, o_frame_error;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int fall_stamp = -100;
  int valid_cnt = 0;
  int err_cnt = 0;
  int lat_bad = 0;
  logic prev_ws = 1'b1;
  logic open_left = 1'b0;
  logic [23:0] got_l_q[$];
  logic [23:0] got_r_q[$];

  i2s_slave_rx #(.d_width(24), .sclk_ws_ratio(64)) dut (
    .mclk(mclk), .reset(reset), .i_sclk(i_sclk), .i_ws(i_ws), .i_sd(i_sd),
    .o_l_data(o_l_data), .o_r_data(o_r_data),
    .o_data_valid(o_data_valid), .o_frame_error(o_frame_error)
  );

  always #5 mclk = ~mclk;

  // Observe outputs on the falling mclk edge, away from the active edge.
  always @(negedge mclk) begin
    cyc++;
    if (o_data_valid) begin
      valid_cnt++;
      got_l_q.push_back(o_l_data);
      got_r_q.push_back(o_r_data);
      if (cyc - fall_stamp != 3) lat_bad++;
    end
    if (o_frame_error) err_cnt++;
  end

  // One sclk period: 2 mclk low (ws/sd change), 2 mclk high.
  task automatic send_bit(input logic ws, input logic sd);
    i_sclk = 1'b0;
    i_ws   = ws;
    i_sd   = sd;
    @(negedge mclk); @(negedge mclk); #1;
    i_sclk = 1'b1;
    if (!ws && prev_ws) fall_stamp = cyc;
    prev_ws = ws;
    @(negedge mclk); @(negedge mclk); #1;
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r,
                            input int lbits, input int rbits);
    for (int i = (open_left ? 1 : 0); i < lbits; i++)
      send_bit(1'b0, (i >= 1 && i <= 24) ? l[24-i] : 1'($urandom_range(0, 1)));
    for (int i = 0; i < rbits; i++)
      send_bit(1'b1, (i >= 1 && i <= 24) ? r[24-i] : 1'($urandom_range(0, 1)));
    open_left = 1'b0;
  endtask

  // Starts the next left slot so the pending frame is emitted.
  task automatic close_frame();
    send_bit(1'b0, 1'($urandom_range(0, 1)));
    open_left = 1'b1;
    repeat (2) @(negedge mclk);
    #1;
  endtask

  task automatic test_reset();
    repeat (4) @(negedge mclk);
    #1;
    vectors++;
    if (o_l_data !== 24'h0) begin miscompares++; $display("FAIL reset_l got %h want 000000", o_l_data); end
    vectors++;
    if (o_r_data !== 24'h0) begin miscompares++; $display("FAIL reset_r got %h want 000000", o_r_data); end
    vectors++;
    if (o_data_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", o_data_valid); end
    vectors++;
    if (o_frame_error !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", o_frame_error); end
    reset = 1'b0;
    repeat (2) @(negedge mclk);
    #1;
  endtask

  task automatic test_basic();
    int v0 = valid_cnt;
    int e0 = err_cnt;
    int l0 = lat_bad;
    got_l_q.delete(); got_r_q.delete();
    for (int i = 0; i < 10; i++) send_bit(1'b1, 1'($urandom_range(0, 1)));
    send_frame(24'h800001, 24'h7FFFFE, 32, 32);
    vectors++;
    if (valid_cnt - v0 !== 0) begin miscompares++; $display("FAIL basic_early_valid got %0d want 0", valid_cnt - v0); end
    close_frame();
    vectors++;
    if (valid_cnt - v0 !== 1) begin miscompares++; $display("FAIL basic_valid_count got %0d want 1", valid_cnt - v0); end
    vectors++;
    if (err_cnt - e0 !== 0) begin miscompares++; $display("FAIL basic_err_count got %0d want 0", err_cnt - e0); end
    vectors++;
    if (lat_bad - l0 !== 0) begin miscompares++; $display("FAIL basic_latency bad %0d want 0", lat_bad - l0); end
    vectors++;
    if (o_l_data !== 24'h800001) begin miscompares++; $display("FAIL basic_l got %h want 800001", o_l_data); end
    vectors++;
    if (o_r_data !== 24'h7FFFFE) begin miscompares++; $display("FAIL basic_r got %h want 7ffffe", o_r_data); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] el[3] = '{24'hA5A5A5, 24'h000000, 24'hFFFFFF};
    logic [23:0] er[3] = '{24'h123456, 24'hFFFFFF, 24'h000001};
    int v0 = valid_cnt;
    got_l_q.delete(); got_r_q.delete();
    for (int k = 0; k < 3; k++) send_frame(el[k], er[k], 32, 32);
    close_frame();
    vectors++;
    if (valid_cnt - v0 !== 3) begin miscompares++; $display("FAIL b2b_valid_count got %0d want 3", valid_cnt - v0); end
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (got_l_q.size() == 0) begin
        miscompares++; $display("FAIL b2b_missing frame %0d got none want %h/%h", k, el[k], er[k]);
      end else begin
        logic [23:0] gl = got_l_q.pop_front();
        logic [23:0] gr = got_r_q.pop_front();
        if (gl !== el[k] || gr !== er[k]) begin
          miscompares++; $display("FAIL b2b_data frame %0d got %h/%h want %h/%h", k, gl, gr, el[k], er[k]);
        end
      end
    end
  endtask

  task automatic test_slot_bounds();
    int v0 = valid_cnt;
    int e0 = err_cnt;
    send_frame(24'h3C3C3C, 24'hC3C3C3, 25, 33);
    close_frame();
    vectors++;
    if (valid_cnt - v0 !== 1 || err_cnt - e0 !== 0) begin
      miscompares++; $display("FAIL bounds_counts got valid %0d err %0d want 1 0", valid_cnt - v0, err_cnt - e0);
    end
    vectors++;
    if (o_l_data !== 24'h3C3C3C || o_r_data !== 24'hC3C3C3) begin
      miscompares++; $display("FAIL bounds_data got %h/%h want 3c3c3c/c3c3c3", o_l_data, o_r_data);
    end
  endtask

  task automatic test_bad_slot(input int lbits, input logic [23:0] gl, input logic [23:0] gr);
    int v0 = valid_cnt;
    int e0 = err_cnt;
    send_frame(24'h555555, 24'h666666, lbits, 32);
    send_frame(gl, gr, 32, 32);
    close_frame();
    vectors++;
    if (err_cnt - e0 !== 1) begin miscompares++; $display("FAIL bad_slot_%0d_err got %0d want 1", lbits, err_cnt - e0); end
    vectors++;
    if (valid_cnt - v0 !== 1) begin miscompares++; $display("FAIL bad_slot_%0d_valid got %0d want 1", lbits, valid_cnt - v0); end
    vectors++;
    if (o_l_data !== gl || o_r_data !== gr) begin
      miscompares++; $display("FAIL bad_slot_%0d_data got %h/%h want %h/%h", lbits, o_l_data, o_r_data, gl, gr);
    end
  endtask

  task automatic test_reset_mid_right();
    int v0 = valid_cnt;
    int e0 = err_cnt;
    for (int i = (open_left ? 1 : 0); i < 32; i++) send_bit(1'b0, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 10; i++) send_bit(1'b1, 1'($urandom_range(0, 1)));
    open_left = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge mclk);
    #1;
    vectors++;
    if (o_l_data !== 24'h0 || o_r_data !== 24'h0) begin
      miscompares++; $display("FAIL midreset_clear got %h/%h want 000000/000000", o_l_data, o_r_data);
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) send_bit(1'b1, 1'($urandom_range(0, 1)));
    vectors++;
    if (valid_cnt - v0 !== 0 || err_cnt - e0 !== 0) begin
      miscompares++; $display("FAIL midreset_quiet got valid %0d err %0d want 0 0", valid_cnt - v0, err_cnt - e0);
    end
    send_frame(24'h0F1E2D, 24'hF0E1D2, 32, 32);
    close_frame();
    vectors++;
    if (valid_cnt - v0 !== 1 || err_cnt - e0 !== 0) begin
      miscompares++; $display("FAIL midreset_counts got valid %0d err %0d want 1 0", valid_cnt - v0, err_cnt - e0);
    end
    vectors++;
    if (o_l_data !== 24'h0F1E2D || o_r_data !== 24'hF0E1D2) begin
      miscompares++; $display("FAIL midreset_data got %h/%h want 0f1e2d/f0e1d2", o_l_data, o_r_data);
    end
  endtask

  task automatic test_stuck_sclk();
    int v0 = valid_cnt;
    int e0 = err_cnt;
    i_sclk = 1'b0;
    repeat (1000) @(negedge mclk);
    #1;
    vectors++;
    if (valid_cnt - v0 !== 0 || err_cnt - e0 !== 0) begin
      miscompares++; $display("FAIL stuck_pulses got valid %0d err %0d want 0 0", valid_cnt - v0, err_cnt - e0);
    end
    vectors++;
    if (o_l_data !== 24'h0F1E2D || o_r_data !== 24'hF0E1D2) begin
      miscompares++; $display("FAIL stuck_hold got %h/%h want 0f1e2d/f0e1d2", o_l_data, o_r_data);
    end
  endtask

  task automatic test_random_frames();
    logic [23:0] exp_l_q[$];
    logic [23:0] exp_r_q[$];
    int v0 = valid_cnt;
    int e0 = err_cnt;
    int l0 = lat_bad;
    got_l_q.delete(); got_r_q.delete();
    for (int k = 0; k < 100; k++) begin
      logic [23:0] l = 24'($urandom);
      logic [23:0] r = 24'($urandom);
      exp_l_q.push_back(l);
      exp_r_q.push_back(r);
      send_frame(l, r, 32, 32);
    end
    close_frame();
    vectors++;
    if (valid_cnt - v0 !== 100) begin miscompares++; $display("FAIL rand_valid_count got %0d want 100", valid_cnt - v0); end
    vectors++;
    if (err_cnt - e0 !== 0) begin miscompares++; $display("FAIL rand_err_count got %0d want 0", err_cnt - e0); end
    vectors++;
    if (lat_bad - l0 !== 0) begin miscompares++; $display("FAIL rand_latency bad %0d want 0", lat_bad - l0); end
    for (int k = 0; k < 100; k++) begin
      logic [23:0] el = exp_l_q.pop_front();
      logic [23:0] er = exp_r_q.pop_front();
      vectors++;
      if (got_l_q.size() == 0) begin
        miscompares++; $display("FAIL rand_missing frame %0d got none want %h/%h", k, el, er);
      end else begin
        logic [23:0] gl = got_l_q.pop_front();
        logic [23:0] gr = got_r_q.pop_front();
        if (gl !== el || gr !== er) begin
          miscompares++; $display("FAIL rand_data frame %0d got %h/%h want %h/%h", k, gl, gr, el, er);
        end
      end
    end
  endtask

  initial begin
    @(negedge mclk);
    #1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_slot_bounds();
    test_bad_slot(16, 24'h13579B, 24'h2468AC);
    test_bad_slot(40, 24'hDEADBE, 24'hEFCAFE);
    test_reset_mid_right();
    test_stuck_sclk();
    test_random_frames();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
